// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// This package holds the default widths, the NOP word and the count-width helper.
package fetch_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] NOP_WORD = '0;

    // Layout of one queued fetch at the default width; the pc sits above the ir.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] ir;
    } fetch_entry_t;

    // The count must be able to hold the value DEPTH itself, not only DEPTH-1.
    function automatic int clog2_p1(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue and its neighbours: imem, the execute redirect and decode.
// The master side is the fetch queue; the slave side is the surrounding pipeline.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 4
);

    localparam int CW = clog2_p1(DEPTH);

    logic [XLEN-1:0] address_imem;
    logic            fetch_req;
    logic [XLEN-1:0] q_imem;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_ir;
    logic [CW-1:0]   count;

    modport master (
        output address_imem, fetch_req, out_valid, out_pc, out_ir, count,
        input  q_imem, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  address_imem, fetch_req, out_valid, out_pc, out_ir, count,
        output q_imem, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter and a single-cycle flush.
// A pushed entry becomes visible at the head on the following cycle; there is no bypass.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [clog2_p1(DEPTH)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = clog2_p1(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push & ~flush;
        do_pop   = pop & ~flush & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush wins over any simultaneous push or pop.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assert property (@(posedge clock) disable iff (!reset) !(push && !flush && full && !pop));
    assert property (@(posedge clock) disable iff (!reset) !(pop && !flush && empty));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: runs the PC, issues one imem read per cycle into a prefetch
// FIFO and presents {pc, ir} to decode; an execute redirect flushes queued and in-flight work.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = XLEN'(NOP_WORD)
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.master bus
);

    localparam int            CW        = clog2_p1(DEPTH);
    localparam int            EW        = 2 * XLEN;
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            issue;
    logic            push, pop;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    entry_t          push_entry;
    entry_t          head;

    // Issue only while queued plus in-flight work leaves room, so the FIFO can never overflow.
    always_comb begin
        occupancy     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
        issue         = reset & ~bus.redirect_valid & (occupancy < DEPTH_OCC);
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + XLEN'(1);
            inflight_pc_d = pc_q;
        end
    end

    // A response that lands during a redirect belongs to the discarded path and is dropped.
    always_comb begin
        pop        = ~fifo_empty & bus.out_ready;
        push       = inflight_q & ~bus.redirect_valid & (~fifo_full | pop);
        push_entry = '{pc: inflight_pc_q, ir: bus.q_imem};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clock) begin
        inflight_pc_q <= inflight_pc_d;
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (push_entry),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Decode sees zeros/NOP rather than stale storage whenever the queue is empty.
    assign bus.address_imem = pc_q;
    assign bus.fetch_req    = issue;
    assign bus.out_valid    = ~fifo_empty;
    assign bus.out_pc       = fifo_empty ? '0 : head.pc;
    assign bus.out_ir       = fifo_empty ? NOP : head.ir;
    assign bus.count        = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a DEPTH=4 instance checked every cycle against a queue model plus
// directed literals, and a DEPTH=2 instance checked against the architectural PC stream.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam logic [31:0] NOP_A = 32'h0000_0013;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc   = '0;
    logic        rdy   = 1'b1;

    int checks = 0;
    int errors = 0;
    int b_pops = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32), .DEPTH(4)) ifa ();
    fetch_queue_if #(.XLEN(32), .DEPTH(2)) ifb ();

    assign ifa.redirect_valid = redir;
    assign ifa.redirect_pc    = rpc;
    assign ifa.out_ready      = rdy;
    assign ifb.redirect_valid = redir;
    assign ifb.redirect_pc    = rpc;
    assign ifb.out_ready      = rdy;

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP(NOP_A)) dut_a (
        .clock (clk),
        .reset (rst_n),
        .bus   (ifa)
    );

    fetch_queue #(.XLEN(32), .DEPTH(2), .RESET_PC(32'h0), .NOP(32'h0)) dut_b (
        .clock (clk),
        .reset (rst_n),
        .bus   (ifb)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle synchronous imem per instance; garbage when nothing was issued.
    initial forever begin
        @(posedge clk);
        ifa.q_imem <= ifa.fetch_req ? imem(ifa.address_imem) : 32'hDEAD_BEEF;
        ifb.q_imem <= ifb.fetch_req ? imem(ifb.address_imem) : 32'hDEAD_BEEF;
    end

    // Behavioural model of the DEPTH=4 instance: queued pcs, pending reads, next fetch pc.
    logic [31:0] mq[$];
    logic [31:0] mpend[$];
    logic [31:0] mfpc = '0;

    function automatic bit m_issue();
        return rst_n && !redir && ((mq.size() + mpend.size()) < 4);
    endfunction

    task automatic m_update();
        bit iss;
        iss = m_issue();
        if (!rst_n) begin
            mq.delete();
            mpend.delete();
            mfpc = '0;
        end else if (redir) begin
            mq.delete();
            mpend.delete();
            mfpc = rpc;
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (mpend.size() > 0) mq.push_back(mpend.pop_front());
            if (iss) begin
                mpend.push_back(mfpc);
                mfpc = mfpc + 32'd1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_update();
    end

    // Per-cycle comparison of instance A against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("a_fetch_req", ifa.fetch_req, m_issue());
            chk("a_address", ifa.address_imem, mfpc);
            chk("a_count", ifa.count, mq.size());
            chk("a_out_valid", ifa.out_valid, mq.size() > 0);
            chk("a_out_pc", ifa.out_pc, (mq.size() > 0) ? mq[0] : 32'h0);
            chk("a_out_ir", ifa.out_ir, (mq.size() > 0) ? imem(mq[0]) : NOP_A);
        end
    end

    // Instance B: accepted pcs must follow the architectural stream, restarting at each redirect.
    initial begin
        logic [31:0] exp_b;
        exp_b = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("b_count_bound", ifb.count <= 2'd2, 1'b1);
            if (!rst_n) begin
                exp_b = '0;
            end else begin
                if (ifb.out_valid && rdy) begin
                    chk("b_stream_pc", ifb.out_pc, exp_b);
                    chk("b_stream_ir", ifb.out_ir, imem(exp_b));
                    exp_b = exp_b + 32'd1;
                    b_pops++;
                end
                if (redir) exp_b = rpc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        redir = 1'b0;
        rpc   = '0;
        step(3);
        chk("rst_count", ifa.count, 0);
        chk("rst_valid", ifa.out_valid, 0);
        chk("rst_ir", ifa.out_ir, NOP_A);
        chk("rst_pc", ifa.out_pc, 0);
        chk("rst_fetch_req", ifa.fetch_req, 0);
        chk("rst_address", ifa.address_imem, 0);

        // Startup with decode always ready.
        rst_n = 1'b1;
        #1;
        chk("start_c0_req", ifa.fetch_req, 1);
        chk("start_c0_addr", ifa.address_imem, 0);
        step();
        chk("start_c1_valid", ifa.out_valid, 0);
        step();
        chk("start_c2_valid", ifa.out_valid, 1);
        chk("start_c2_pc", ifa.out_pc, 32'h0);
        chk("start_c2_ir", ifa.out_ir, 32'h1000);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("stream_pc", ifa.out_pc, i);
            chk("stream_ir", ifa.out_ir, 32'h1000 + i);
        end

        // Decode stalled from reset: fill to DEPTH, then drain in order.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rdy   = 1'b0;
        step(6);
        chk("fill_count", ifa.count, 4);
        chk("fill_req", ifa.fetch_req, 0);
        chk("fill_addr", ifa.address_imem, 4);
        step(3);
        chk("hold_count", ifa.count, 4);
        chk("hold_addr", ifa.address_imem, 4);
        rdy = 1'b1;
        #1;
        for (int i = 0; i <= 4; i++) begin
            chk("drain_pc", ifa.out_pc, i);
            chk("drain_ir", ifa.out_ir, 32'h1000 + i);
            step();
        end

        // Redirect with three queued entries and one read in flight.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rdy   = 1'b0;
        step(4);
        chk("pre_redir_count", ifa.count, 3);
        redir = 1'b1;
        rpc   = 32'h40;
        #1;
        chk("redir_no_issue", ifa.fetch_req, 0);
        step();
        redir = 1'b0;
        #1;
        chk("post_redir_count", ifa.count, 0);
        chk("post_redir_valid", ifa.out_valid, 0);
        chk("post_redir_ir", ifa.out_ir, NOP_A);
        chk("post_redir_addr", ifa.address_imem, 32'h40);
        step();
        chk("stale_dropped", ifa.count, 0);
        step();
        chk("target_valid", ifa.out_valid, 1);
        chk("target_pc", ifa.out_pc, 32'h40);
        chk("target_ir", ifa.out_ir, 32'h1040);

        // Redirect coinciding with a pop while full.
        for (int i = 0; i < 10 && ifa.count != 3'd4; i++) step();
        chk("full_before_redir", ifa.count, 4);
        rdy   = 1'b1;
        redir = 1'b1;
        rpc   = 32'h80;
        #1;
        chk("popped_head_pc", ifa.out_pc, 32'h40);
        step();
        redir = 1'b0;
        #1;
        chk("flush_count", ifa.count, 0);
        chk("flush_valid", ifa.out_valid, 0);
        step(2);
        chk("target2_pc", ifa.out_pc, 32'h80);

        // Reset in the middle of a running stream.
        step(3);
        rst_n = 1'b0;
        step();
        chk("midrst_count", ifa.count, 0);
        chk("midrst_valid", ifa.out_valid, 0);
        chk("midrst_pc", ifa.out_pc, 0);
        chk("midrst_ir", ifa.out_ir, NOP_A);
        chk("midrst_addr", ifa.address_imem, 0);
        rst_n = 1'b1;
        #1;
        step(2);
        chk("restart_pc", ifa.out_pc, 0);
        chk("restart_ir", ifa.out_ir, 32'h1000);

        // Back-to-back redirects: the later target wins.
        redir = 1'b1;
        rpc   = 32'h100;
        step();
        rpc = 32'h200;
        step();
        redir = 1'b0;
        #1;
        chk("b2b_addr", ifa.address_imem, 32'h200);
        step(2);
        chk("b2b_pc", ifa.out_pc, 32'h200);

        // Random decode stalls, redirects and occasional resets.
        for (int i = 0; i < 10000; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = $urandom_range(0, 255);
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        redir = 1'b0;
        rst_n = 1'b1;
        step(2);
        chk("b_progress", b_pops > 1000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that decouples imem from decode.
- Runs the PC, issues one imem read per cycle into a DEPTH-entry prefetch FIFO, and presents {pc, ir} to decode over a valid/ready handshake.
- Supports redirect (branch/jump/jr resolved in execute): flushes queued and in-flight fetches.
- Replaces the fixed single-register PC + FD latch, so a decode stall no longer starves imem.

Parameters:
- XLEN, 32, data/address width; PC is a word address, incremented by 1.
- DEPTH, 4, prefetch FIFO entries; power of 2, at least 2.
- RESET_PC, 0, PC value after reset.
- NOP, 0, instruction word driven on out_ir when the queue is empty.

Ports:
- clock  in  1  master clock, rising-edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- address_imem  out  XLEN  fetch address (current fetch PC).
- fetch_req  out  1  high when a read issues this cycle.
- q_imem  in  XLEN  imem data, valid the cycle after issue (1-cycle synchronous imem).
- redirect_valid  in  1  pulse: discard all fetched or in-flight instructions and restart.
- redirect_pc  in  XLEN  restart target; sampled only when redirect_valid=1.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts the head this cycle (the inverse of the decode stall).
- out_pc  out  XLEN  PC of the head entry.
- out_ir  out  XLEN  instruction at the head entry; NOP when out_valid=0.
- count  out  $clog2(DEPTH)+1  entries currently held.

Behaviour:
- Reset (reset=0 at an edge): pc_q=RESET_PC, FIFO pointers=0, count=0, inflight=0, out_valid=0, out_pc=0, out_ir=NOP, fetch_req=0. Reset mid-operation drops everything, including an in-flight read.
- Issue condition: fetch_req = reset & !redirect_valid & (count + inflight < DEPTH). This guarantees FIFO overflow is impossible.
- On issue:
  - pc_q <= pc_q+1; inflight <= 1; inflight_pc <= pc_q.
  - Without issue, inflight <= 0.
- Response: in the cycle after issue, q_imem and inflight_pc are pushed into the FIFO if inflight=1 and redirect_valid=0.
- Pop: occurs when out_valid & out_ready; rd_ptr advances.
- Push and pop in the same cycle:
  - Allowed at any occupancy, including full.
  - count stays unchanged.
  - A newly written entry is visible from the next cycle; there is no bypass.
- Pointers are log2(DEPTH) bits wide and wrap naturally; count is tracked separately.
- Redirect at edge E0:
  - count=0; pointers reset; inflight cleared, and a response arriving in the cycle after E0 is dropped.
  - pc_q <= redirect_pc.
  - No issue in the E0 cycle.
  - Target issues in the cycle after E0; target out_valid=1 after E2. Redirect-to-valid latency is 2 cycles.
- Redirect priority: redirect beats a simultaneous pop, push, or issue. A pop in the redirect cycle is still consumed by decode; the flush discards the rest.
- Redirect with out_valid=0 or an empty FIFO is legal and has the same behaviour.
- Back-to-back redirects: the last one wins.
- Steady state with out_ready=1:
  - One instruction per cycle once filled.
  - Startup latency from reset release to the first out_valid is 2 cycles.
- out_ready=0 sustained:
  - Fills to exactly DEPTH entries, then fetch_req=0.
  - pc_q holds at (last issued PC)+1.
- Outputs out_pc, out_ir, and out_valid are combinational reads of the FIFO head and count.

Decomposition:
- Shared package fetch_pkg:
  - NOP word.
  - XLEN default.
  - Function clog2_p1 for count width.
  - Typedef fetch_entry_t {pc, ir}.
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports push, pop, flush, din, dout, count, full, empty.
  - Synchronous active-low reset, same as the parent.
- The parent holds the PC, the issue logic, and the inflight/drop logic.

Test Plan:
- Reset release, out_ready=1, imem[k]=0x1000+k:
  - fetch_req=1 from cycle 0.
  - out_valid at cycle 2 with pc=0, ir=0x1000.
  - Then one entry per cycle: pc 1, 2, 3…
- out_ready=0 from reset, DEPTH=4:
  - count reaches 4.
  - fetch_req stays 0 thereafter; address_imem=4 and stable.
  - Releasing out_ready drains pc 0..3, then 4 follows.
- Redirect to 0x40 while count=3 and inflight=1:
  - Next cycle count=0, out_valid=0, out_ir=NOP.
  - The stale response is not pushed.
  - out_pc=0x40 appears 2 cycles after the redirect edge.
- Redirect coincident with out_valid&out_ready and with the FIFO full:
  - Head is consumed; remaining entries are flushed.
  - No overflow; count=0.
- reset=0 asserted mid-stream with inflight=1:
  - All outputs return to reset values on that edge.
  - Fetch restarts at RESET_PC with no stale entry.
- DEPTH=2 regression with random out_ready/redirect for 10k cycles:
  - Scoreboard shows the out_pc sequence matches the architectural PC stream.
  - count never exceeds DEPTH.
